// File: rtl/simd_add_arbiter_if.sv
// rtl/simd_add_arbiter_if.sv - requester, adder and response signals of simd_add_arbiter
//
// Purpose: bundles the requester-side request/operand bus, the grant, the
// shared-adder control/operand/sum signals and the response bus.
// Ports (modport slave = the arbiter, modport master = requesters + adder):
//   req/req_a/req_b    requester requests and packed 4x10-bit lane operands
//   gnt                one-hot grant (issue in this cycle)
//   add_start/add_ce   adder start and clock enable
//   add_a/add_b        operands to the adder lanes
//   add_z/add_z_vld    adder sums and common sum valid
//   rsp_vld/rsp_id/rsp_z  response pulse, owning requester, sums
interface simd_add_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
);
  logic [NREQ-1:0]    req;
  logic [NREQ*40-1:0] req_a;
  logic [NREQ*40-1:0] req_b;
  logic [NREQ-1:0]    gnt;
  logic               add_start;
  logic               add_ce;
  logic [39:0]        add_a;
  logic [39:0]        add_b;
  logic [39:0]        add_z;
  logic               add_z_vld;
  logic               rsp_vld;
  logic [IDW-1:0]     rsp_id;
  logic [39:0]        rsp_z;

  modport slave (
    input  req, req_a, req_b, add_z, add_z_vld,
    output gnt, add_start, add_ce, add_a, add_b, rsp_vld, rsp_id, rsp_z
  );

  modport master (
    output req, req_a, req_b, add_z, add_z_vld,
    input  gnt, add_start, add_ce, add_a, add_b, rsp_vld, rsp_id, rsp_z
  );
endinterface

// File: rtl/simd_add_arbiter.sv
// rtl/simd_add_arbiter.sv - round-robin arbiter in front of a pipelined 4-lane SIMD adder
//
// Purpose: picks one requester per cycle (round robin from ptr), drives the
// shared adder, tracks requester tags through a shadow pipeline matched to the
// adder latency, returns each sum tagged with its owner and flags tag/valid
// misalignment.
// Ports:
//   ap_clk   clock
//   ap_rst   asynchronous active-high reset
//   en       global enable; low freezes adder and shadow pipeline
//   bus      simd_add_arbiter_if.slave (requests, grant, adder, responses)
//   busy     one or more operations in flight
//   err      sticky tag/valid mismatch
module simd_add_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int IDW  = 3
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  en,
  simd_add_arbiter_if.slave     bus,
  output logic                  busy,
  output logic                  err
);

  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [LAT-1:0]          shd_vld_q, shd_vld_d;
  logic [LAT-1:0][IDW-1:0] shd_id_q, shd_id_d;
  logic                    rsp_vld_q, rsp_vld_d;
  logic [IDW-1:0]          rsp_id_q, rsp_id_d;
  logic [39:0]             rsp_z_q, rsp_z_d;
  logic                    err_q, err_d;

  logic                    gnt_any;
  logic [IDW-1:0]          gnt_idx;
  int                      off;
  int                      best_off;
  logic [39:0]             mux_a, mux_b;

  // Round-robin pick: the requester with the smallest rotated distance from
  // ptr wins. ptr_q is always < NREQ, so the distance never goes negative.
  always_comb begin
    gnt_idx  = '0;
    best_off = NREQ;
    off      = 0;
    for (int i = 0; i < NREQ; i++) begin
      off = (i + NREQ - int'(ptr_q)) % NREQ;
      if (bus.req[i] && (off < best_off)) begin
        best_off = off;
        gnt_idx  = IDW'(i);
      end
    end
    gnt_any = en && (best_off < NREQ);
  end

  // Operand mux; requester 0 is presented when idle.
  always_comb begin
    mux_a = bus.req_a[39:0];
    mux_b = bus.req_b[39:0];
    for (int i = 1; i < NREQ; i++) begin
      if (gnt_any && (gnt_idx == IDW'(i))) begin
        mux_a = bus.req_a[i*40 +: 40];
        mux_b = bus.req_b[i*40 +: 40];
      end
    end
  end

  assign bus.gnt       = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
  assign bus.add_start = gnt_any;
  assign bus.add_ce    = en;
  assign bus.add_a     = mux_a;
  assign bus.add_b     = mux_b;

  always_comb begin
    ptr_d     = ptr_q;
    shd_vld_d = shd_vld_q;
    shd_id_d  = shd_id_q;
    rsp_vld_d = 1'b0;
    rsp_id_d  = rsp_id_q;
    rsp_z_d   = rsp_z_q;
    err_d     = err_q;

    if (gnt_any) begin
      ptr_d = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
    end

    if (en) begin
      shd_vld_d[0] = gnt_any;
      shd_id_d[0]  = gnt_idx;
      for (int j = 1; j < LAT; j++) begin
        shd_vld_d[j] = shd_vld_q[j-1];
        shd_id_d[j]  = shd_id_q[j-1];
      end
      // The last shadow stage lines up with the adder output on this edge.
      rsp_vld_d = shd_vld_q[LAT-1];
      if (shd_vld_q[LAT-1]) begin
        rsp_id_d = shd_id_q[LAT-1];
        rsp_z_d  = bus.add_z;
      end
      if (shd_vld_q[LAT-1] != bus.add_z_vld) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ptr_q     <= '0;
      shd_vld_q <= '0;
      shd_id_q  <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
      rsp_z_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      shd_vld_q <= shd_vld_d;
      shd_id_q  <= shd_id_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
      rsp_z_q   <= rsp_z_d;
      err_q     <= err_d;
    end
  end

  assign bus.rsp_vld = rsp_vld_q;
  assign bus.rsp_id  = rsp_id_q;
  assign bus.rsp_z   = rsp_z_q;
  assign busy        = |shd_vld_q;
  assign err         = err_q;

endmodule

// File: tb/tb_simd_add_arbiter.sv
// tb/tb_simd_add_arbiter.sv - directed self-checking bench for simd_add_arbiter
module tb_simd_add_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int IDW  = 3;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic en     = 1'b0;
  logic inject = 1'b0;
  logic busy;
  logic err;

  int n_chk  = 0;
  int n_pass = 0;

  simd_add_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  simd_add_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .en     (en),
    .bus    (bus),
    .busy   (busy),
    .err    (err)
  );

  always #5 ap_clk = ~ap_clk;

  // Two-stage pipelined 4-lane adder sharing the arbiter's reset.
  logic        s1_vld, mdl_vld;
  logic [39:0] s1_a, s1_b, mdl_z;
  always @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      s1_vld  <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      mdl_vld <= 1'b0;
      mdl_z   <= '0;
    end else if (bus.add_ce) begin
      s1_vld  <= bus.add_start;
      s1_a    <= bus.add_a;
      s1_b    <= bus.add_b;
      mdl_vld <= s1_vld;
      for (int k = 0; k < 4; k++) mdl_z[k*10 +: 10] <= s1_a[k*10 +: 10] + s1_b[k*10 +: 10];
    end
  end
  assign bus.add_z     = mdl_z;
  assign bus.add_z_vld = mdl_vld | inject;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [39:0] l4(input logic [9:0] v);
    return {4{v}};
  endfunction

  task automatic set_ops(input int i, input logic [9:0] a, input logic [9:0] b);
    bus.req_a[i*40 +: 40] = l4(a);
    bus.req_b[i*40 +: 40] = l4(b);
  endtask

  task automatic next_cycle();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [9:0] sum_of [NREQ];

  initial begin
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;

    // reset state
    repeat (2) next_cycle();
    settle();
    check("rst_gnt", bus.gnt, 0);
    check("rst_add_start", bus.add_start, 0);
    check("rst_rsp_vld", bus.rsp_vld, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_z", bus.rsp_z, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    ap_rst = 1'b0;

    // single request: 5+7 on every lane, response three cycles later
    next_cycle();
    en = 1'b1;
    set_ops(0, 10'd5, 10'd7);
    bus.req = 4'b0001;
    settle();
    check("t1_gnt", bus.gnt, 4'b0001);
    check("t1_start", bus.add_start, 1);
    check("t1_ce", bus.add_ce, 1);
    check("t1_add_a", bus.add_a, l4(10'd5));
    check("t1_add_b", bus.add_b, l4(10'd7));
    next_cycle();
    bus.req = 4'b0000;
    settle();
    check("t1_c1_gnt", bus.gnt, 0);
    check("t1_c1_busy", busy, 1);
    check("t1_c1_vld", bus.rsp_vld, 0);
    next_cycle();
    settle();
    check("t1_c2_vld", bus.rsp_vld, 0);
    next_cycle();
    settle();
    check("t1_c3_vld", bus.rsp_vld, 1);
    check("t1_c3_id", bus.rsp_id, 0);
    check("t1_c3_z", bus.rsp_z, l4(10'd12));
    next_cycle();
    settle();
    check("t1_c4_vld", bus.rsp_vld, 0);
    check("t1_c4_z_hold", bus.rsp_z, l4(10'd12));
    check("t1_c4_busy", busy, 0);
    check("t1_c4_err", err, 0);

    // all four requesting from ptr=0
    ap_rst = 1'b1;
    settle();
    ap_rst = 1'b0;
    set_ops(0, 10'd100, 10'd1);
    set_ops(1, 10'd200, 10'd4);
    set_ops(2, 10'd300, 10'd7);
    set_ops(3, 10'd400, 10'd10);
    sum_of[0] = 10'd101;
    sum_of[1] = 10'd204;
    sum_of[2] = 10'd307;
    sum_of[3] = 10'd410;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      bus.req = (c < 8) ? 4'b1111 : 4'b0000;
      settle();
      check($sformatf("rr_gnt_c%0d", c), bus.gnt, (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000);
      if (c >= 3 && c < 11) begin
        check($sformatf("rr_vld_c%0d", c), bus.rsp_vld, 1);
        check($sformatf("rr_id_c%0d", c), bus.rsp_id, (c - 3) % 4);
        check($sformatf("rr_z_c%0d", c), bus.rsp_z, l4(sum_of[(c - 3) % 4]));
      end else begin
        check($sformatf("rr_novld_c%0d", c), bus.rsp_vld, 0);
      end
    end

    // pointer wrap: grant 2 (ptr->3), then {1,0} wraps to 0, then 1
    next_cycle();
    bus.req = 4'b0100;
    settle();
    check("wrap_gnt2", bus.gnt, 4'b0100);
    next_cycle();
    bus.req = 4'b0011;
    settle();
    check("wrap_gnt0", bus.gnt, 4'b0001);
    next_cycle();
    bus.req = 4'b0010;
    settle();
    check("wrap_gnt1", bus.gnt, 4'b0010);
    next_cycle();
    bus.req = 4'b0000;
    settle();
    check("wrap_id_a", bus.rsp_id, 2);
    check("wrap_z_a", bus.rsp_z, l4(sum_of[2]));
    next_cycle();
    settle();
    check("wrap_id_b", bus.rsp_id, 0);
    next_cycle();
    settle();
    check("wrap_id_c", bus.rsp_id, 1);
    check("wrap_vld_c", bus.rsp_vld, 1);

    // lane overflow: 3FF + 002 wraps to 001
    set_ops(3, 10'h3FF, 10'h002);
    next_cycle();
    bus.req = 4'b1000;
    settle();
    check("ovf_gnt", bus.gnt, 4'b1000);
    next_cycle();
    bus.req = 4'b0000;
    repeat (2) next_cycle();
    settle();
    check("ovf_vld", bus.rsp_vld, 1);
    check("ovf_id", bus.rsp_id, 3);
    check("ovf_z", bus.rsp_z, l4(10'h001));
    check("ovf_err", err, 0);

    // stall: en low for four cycles after the first pipeline step
    next_cycle();
    bus.req = 4'b0001;
    settle();
    check("stall_gnt", bus.gnt, 4'b0001);
    next_cycle();
    bus.req = 4'b0000;
    settle();
    check("stall_c1_vld", bus.rsp_vld, 0);
    for (int c = 2; c < 6; c++) begin
      next_cycle();
      en = 1'b0;
      bus.req = 4'b0010;
      settle();
      check($sformatf("stall_ce_c%0d", c), bus.add_ce, 0);
      check($sformatf("stall_gnt_c%0d", c), bus.gnt, 0);
      check($sformatf("stall_busy_c%0d", c), busy, 1);
      check($sformatf("stall_vld_c%0d", c), bus.rsp_vld, 0);
    end
    next_cycle();
    en = 1'b1;
    bus.req = 4'b0000;
    settle();
    check("stall_c6_vld", bus.rsp_vld, 0);
    check("stall_c6_busy", busy, 1);
    next_cycle();
    settle();
    check("stall_c7_vld", bus.rsp_vld, 1);
    check("stall_c7_id", bus.rsp_id, 0);
    check("stall_c7_z", bus.rsp_z, l4(sum_of[0]));
    next_cycle();
    settle();
    check("stall_c8_err", err, 0);
    check("stall_c8_vld", bus.rsp_vld, 0);

    // reset with two ops in flight (ptr=1 here)
    next_cycle();
    bus.req = 4'b0011;
    settle();
    check("inflt_gnt1", bus.gnt, 4'b0010);
    next_cycle();
    settle();
    check("inflt_gnt0", bus.gnt, 4'b0001);
    next_cycle();
    bus.req = 4'b0000;
    settle();
    check("inflt_busy", busy, 1);
    ap_rst = 1'b1;
    settle();
    check("arst_gnt", bus.gnt, 0);
    check("arst_rsp_vld", bus.rsp_vld, 0);
    check("arst_rsp_id", bus.rsp_id, 0);
    check("arst_rsp_z", bus.rsp_z, 0);
    check("arst_busy", busy, 0);
    check("arst_err", err, 0);
    next_cycle();
    ap_rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      settle();
      check($sformatf("post_rst_vld_c%0d", c), bus.rsp_vld, 0);
      check($sformatf("post_rst_err_c%0d", c), err, 0);
    end
    next_cycle();
    bus.req = 4'b1111;
    settle();
    check("post_rst_ptr0", bus.gnt, 4'b0001);
    next_cycle();
    bus.req = 4'b0000;
    repeat (4) next_cycle();
    settle();
    check("idle_busy", busy, 0);
    check("idle_err", err, 0);

    // injected valid with nothing in flight sets err until reset
    inject = 1'b1;
    next_cycle();
    inject = 1'b0;
    settle();
    check("inj_err_set", err, 1);
    repeat (3) next_cycle();
    settle();
    check("inj_err_sticky", err, 1);
    ap_rst = 1'b1;
    settle();
    check("inj_err_clr", err, 0);
    ap_rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
